pipe_mem_wb_mc: RTL
===================

Name: pipe_mem_wb_mc

Overview:
Parametrised MEM/WB pipeline register, successor to the single-channel MEM/WB stage. Carries NUM_CH independent register-write channels (multi-issue) from MEM to WB. Adds stall-bubble insertion, flush, per-channel valid, x0 write suppression and same-cycle write-conflict resolution. Sits between the MEM stage and the register file write ports; stall vector comes from the central ctrl block.

Parameters:
NUM_CH, 2, number of write channels (1..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
mem_reg_waddr  input  NUM_CH*ADDR_W  per-channel destination address; channel i at bits [i*ADDR_W +: ADDR_W]
mem_we  input  NUM_CH  per-channel write enable
mem_reg_wdata  input  NUM_CH*DATA_W  per-channel write data; channel i at [i*DATA_W +: DATA_W]
mem_valid  input  NUM_CH  per-channel instruction valid
stall  input  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
flush  input  1  squash stage contents
wb_reg_waddr  output  NUM_CH*ADDR_W  registered address
wb_we  output  NUM_CH  registered, sanitised write enable
wb_reg_wdata  output  NUM_CH*DATA_W  registered data
wb_valid  output  NUM_CH  registered valid

Behaviour:
- All outputs registered; latency 1 cycle from MEM inputs to WB outputs.
- Reset (rst=1 at edge): all outputs 0. Reset has priority over flush and stall.
- Priority per edge: rst > flush > stall > advance.
- flush=1: load bubble (all outputs 0) regardless of stall.
- stall[4]=1 and stall[5]=0: MEM held, WB proceeds -> load bubble (all outputs 0).
- stall[4]=1 and stall[5]=1: hold all outputs unchanged.
- stall[4]=0: advance; capture sanitised inputs. stall[5]=1 with stall[4]=0 is illegal from ctrl; block treats it as advance (no assertion in RTL).
- Sanitisation per channel i before capture:
  - eff_we[i] = mem_we[i] & mem_valid[i] & (waddr[i] != 0). x0 writes never reach WB.
  - Conflict: if eff_we[i] and eff_we[j], j>i, with equal addresses, eff_we[i] cleared (higher channel = younger instruction wins). Resolved over all pairs combinationally.
  - waddr, wdata, valid captured as presented even when we is cleared.
- Stall bits 0-3 ignored.
- Hold after bubble keeps zeros; hold never re-issues a write twice to the register file only because WB consumes on every cycle stall[5]=0.
- NUM_CH=1: conflict logic degenerates away; behaviour matches a single-channel MEM/WB register plus x0 suppression, valid and flush.

Optional Feature:
Macro RETIRE_CNT_EN. When defined: extra output retire_cnt (64 bits) counting instructions retired through WB. Each cycle stall[5]=0, adds popcount(wb_valid) of the current registered outputs; reset clears to 0; flush does not clear; wraps modulo 2^64. When not defined: port and counter absent; no other behaviour change.

Test Plan:
- Reset: drive inputs nonzero, rst=1 one cycle -> all outputs 0 next cycle; with RETIRE_CNT_EN, retire_cnt=0.
- Advance: NUM_CH=2, ch0 waddr=3 wdata=0xDEADBEEF we=1 valid=1, ch1 waddr=7 wdata=0x12345678 we=1 valid=1, stall=0 -> next cycle wb outputs equal inputs, wb_we=2'b11.
- x0/conflict: ch0 waddr=0 we=1 -> wb_we[0]=0; then ch0 and ch1 both waddr=5 we=1 -> wb_we=2'b10, wb_reg_wdata ch0 still captured.
- Stall bubble/hold: load valid data, then stall=6'b010000 -> outputs 0; then stall=6'b110000 with new data -> outputs stay 0; load data then stall=6'b110000 -> outputs held for 3 cycles.
- Flush priority: stall=6'b110000 and flush=1 with valid outputs -> outputs 0 next cycle; rst=1 with flush=1 -> outputs 0.
- Retire count (RETIRE_CNT_EN): 4 cycles of 2 valid instructions, stall=0 -> retire_cnt=8 one cycle after last; 2 cycles stall[5]=1 -> count unchanged.

Source files
------------

// File: rtl/pipe_mem_wb_mc.sv
// pipe_mem_wb_mc: multi-channel MEM/WB pipeline register.
// Each of the NUM_CH write channels is registered with one cycle of latency.
// The stage supports stall bubbles, stall holds and flush.
// Write enables are cleaned before capture: an invalid instruction or an x0
// destination never writes, and when two channels write the same register
// only the younger (higher-numbered) channel keeps its write.
// Optional macro RETIRE_CNT_EN adds a 64-bit retire_cnt output that counts
// the instructions retired through WB.
module pipe_mem_wb_mc #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*ADDR_W-1:0] mem_reg_waddr,
  input  logic [NUM_CH-1:0]        mem_we,
  input  logic [NUM_CH*DATA_W-1:0] mem_reg_wdata,
  input  logic [NUM_CH-1:0]        mem_valid,
  input  logic [5:0]               stall,
  input  logic                     flush,
  output logic [NUM_CH*ADDR_W-1:0] wb_reg_waddr,
  output logic [NUM_CH-1:0]        wb_we,
  output logic [NUM_CH*DATA_W-1:0] wb_reg_wdata,
  output logic [NUM_CH-1:0]        wb_valid
`ifdef RETIRE_CNT_EN
  ,
  output logic [63:0]              retire_cnt
`endif
);

  localparam int NCH = int'(NUM_CH);
  localparam int unsigned CNT_W = 64;

  logic [NUM_CH-1:0] base_we;
  logic [NUM_CH-1:0] kill_we;
  logic [NUM_CH-1:0] eff_we;
  logic              bubble;

  // Only stall bits 4 (MEM) and 5 (WB) affect this stage.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  // Clean the write enables: drop invalid and x0 writes, and let the younger channel win on an address clash.
  always_comb begin
    base_we = '0;
    kill_we = '0;
    for (int i = 0; i < NCH; i++) begin
      base_we[i] = mem_we[i] & mem_valid[i] &
                   (mem_reg_waddr[i*ADDR_W +: ADDR_W] != '0);
    end
    for (int i = 0; i < NCH; i++) begin
      for (int j = i + 1; j < NCH; j++) begin
        if (base_we[i] && base_we[j] &&
            (mem_reg_waddr[i*ADDR_W +: ADDR_W] == mem_reg_waddr[j*ADDR_W +: ADDR_W])) begin
          kill_we[i] = 1'b1;
        end
      end
    end
    eff_we = base_we & ~kill_we;
  end

  // A flush, or a MEM stall while WB keeps running, loads an empty stage.
  assign bubble = flush | (stall[4] & ~stall[5]);

  // Stage register. Priority is reset, then bubble, then advance. A stall of both MEM and WB holds the stage.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      wb_reg_waddr <= '0;
      wb_we        <= '0;
      wb_reg_wdata <= '0;
      wb_valid     <= '0;
    end else if (!stall[4]) begin
      wb_reg_waddr <= mem_reg_waddr;
      wb_we        <= eff_we;
      wb_reg_wdata <= mem_reg_wdata;
      wb_valid     <= mem_valid;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_inc;

  // Count the valid instructions that WB consumes in this cycle.
  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < NCH; i++) begin
      retire_inc = retire_inc + CNT_W'(wb_valid[i]);
    end
  end

  // Retire counter. Reset clears it, a flush leaves it alone, and it wraps modulo 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (!stall[5]) begin
      retire_cnt <= retire_cnt + retire_inc;
    end
  end
`endif

endmodule
